// File: rtl/fxyz_checker.sv
// -----------------------------------------------------------------------------
// fxyz_checker
// Response monitor for the fxyz boolean block. Every accepted vector carries
// the stimulus (x, y, z) and the observed outputs (s1, s2). The observed
// outputs are compared against s1 = ~(x & y) and s2 = x & ~y. The block
// accumulates a saturating error count, a vector count, minterm coverage and
// a first-failure capture, and it reports a pass/fail verdict when the run ends.
//
// Parameters
//   AUTO_STOP : 1 = enter DONE automatically once all 8 minterms are covered
//   ERR_W     : width of the saturating error counter
//
// Ports
//   clk             in   rising-edge clock
//   reset_n         in   synchronous active-low reset
//   start           in   clear all results and enter RUN (1-cycle pulse)
//   stop            in   end the run and enter DONE
//   in_valid        in   vector present on x, y, z, s1, s2
//   in_ready        out  vectors are accepted (high only in RUN)
//   x, y, z         in   stimulus applied to fxyz
//   s1, s2          in   fxyz outputs observed for that stimulus
//   busy            out  high in RUN
//   done            out  high in DONE (level)
//   pass            out  done with zero errors and full coverage
//   err_cnt         out  mismatching vectors, saturating
//   vec_cnt         out  accepted vectors, saturating at 255
//   cov             out  bit {x,y,z} set once that minterm was accepted
//   first_err_valid out  a mismatch has been captured
//   first_err_vec   out  {x,y,z,s1,s2} of the first mismatching vector
// -----------------------------------------------------------------------------
module fxyz_checker #(
    parameter bit AUTO_STOP = 1'b1,
    parameter int ERR_W     = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             x,
    input  logic             y,
    input  logic             z,
    input  logic             s1,
    input  logic             s2,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [7:0]       vec_cnt,
    output logic [7:0]       cov,
    output logic             first_err_valid,
    output logic [4:0]       first_err_vec
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ZERO = {ERR_W{1'b0}};
    localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

    // Golden fxyz response, packed as {s1, s2}; z does not influence it.
    function automatic logic [1:0] fxyz_golden(input logic gx, input logic gy);
        return {~(gx & gy), gx & ~gy};
    endfunction

    state_e           state_r, state_s;
    logic [ERR_W-1:0] err_cnt_r, err_cnt_s;
    logic [7:0]       vec_cnt_r, vec_cnt_s;
    logic [7:0]       cov_r, cov_s;
    logic             fev_r, fev_s;
    logic [4:0]       fv_r, fv_s;
    logic             in_ready_r, busy_r, done_r, pass_r;
    logic             accept_s;
    logic             mismatch_s;
    logic [1:0]       expect_s;

    // Mismatch detection; case-inequality also flags X/Z on any observed bit.
    always_comb begin
        expect_s   = fxyz_golden(x, y);
        mismatch_s = (s1 !== expect_s[1]) || (s2 !== expect_s[0]) ||
                     ((^{x, y, z, s1, s2}) === 1'bx);
    end

    // Next-state and next-result logic; start has priority over stop and auto-stop.
    always_comb begin
        state_s   = state_r;
        err_cnt_s = err_cnt_r;
        vec_cnt_s = vec_cnt_r;
        cov_s     = cov_r;
        fev_s     = fev_r;
        fv_s      = fv_r;
        accept_s  = 1'b0;
        if (start) begin
            // A vector offered together with start is discarded.
            state_s   = ST_RUN;
            err_cnt_s = ERR_ZERO;
            vec_cnt_s = 8'd0;
            cov_s     = 8'd0;
            fev_s     = 1'b0;
            fv_s      = 5'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    accept_s = in_valid & in_ready_r;
                    if (accept_s) begin
                        if (vec_cnt_r != 8'd255) begin
                            vec_cnt_s = vec_cnt_r + 8'd1;
                        end else begin
                            vec_cnt_s = vec_cnt_r;
                        end
                        cov_s[{x, y, z}] = 1'b1;
                        if (mismatch_s) begin
                            if (err_cnt_r != ERR_MAX) begin
                                err_cnt_s = err_cnt_r + ERR_ONE;
                            end else begin
                                err_cnt_s = err_cnt_r;
                            end
                            if (!fev_r) begin
                                fev_s = 1'b1;
                                fv_s  = {x, y, z, s1, s2};
                            end else begin
                                fev_s = fev_r;
                            end
                        end else begin
                            err_cnt_s = err_cnt_r;
                        end
                    end else begin
                        cov_s = cov_r;
                    end
                    // The vector accepted this cycle is already folded in above.
                    if (stop) begin
                        state_s = ST_DONE;
                    end else if (AUTO_STOP && accept_s && (cov_s == 8'hFF)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_IDLE: state_s = ST_IDLE;
                ST_DONE: state_s = ST_DONE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State, results and status outputs, all registered from the next-state values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            err_cnt_r  <= ERR_ZERO;
            vec_cnt_r  <= 8'd0;
            cov_r      <= 8'd0;
            fev_r      <= 1'b0;
            fv_r       <= 5'd0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pass_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            err_cnt_r  <= err_cnt_s;
            vec_cnt_r  <= vec_cnt_s;
            cov_r      <= cov_s;
            fev_r      <= fev_s;
            fv_r       <= fv_s;
            in_ready_r <= (state_s == ST_RUN);
            busy_r     <= (state_s == ST_RUN);
            done_r     <= (state_s == ST_DONE);
            pass_r     <= (state_s == ST_DONE) && (err_cnt_s == ERR_ZERO) &&
                          (cov_s == 8'hFF);
        end
    end

    assign in_ready        = in_ready_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign err_cnt         = err_cnt_r;
    assign vec_cnt         = vec_cnt_r;
    assign cov             = cov_r;
    assign first_err_valid = fev_r;
    assign first_err_vec   = fv_r;

endmodule

// File: tb/tb_fxyz_checker.sv
// -----------------------------------------------------------------------------
// Bench for fxyz_checker. The stimulus process queues the expected result
// snapshot for each checkpoint; a monitor pops and compares whenever done
// rises or the stimulus marks a checkpoint.
// -----------------------------------------------------------------------------
module tb_fxyz_checker;

    logic       clk = 1'b0;
    logic       reset_n, start, stop, in_valid;
    logic       x, y, z, s1, s2;
    logic       in_ready, busy, done, pass, first_err_valid;
    logic [3:0] err_cnt;
    logic [7:0] vec_cnt, cov;
    logic [4:0] first_err_vec;

    always #5 clk = ~clk;

    fxyz_checker #(.AUTO_STOP(1'b1), .ERR_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .z(z), .s1(s1), .s2(s2),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .vec_cnt(vec_cnt), .cov(cov),
        .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
    );

    typedef struct {
        string      name;
        logic       done_e, pass_e, busy_e, ready_e, fev_e;
        logic [3:0] err_e;
        logic [7:0] vec_e, cov_e;
        logic [4:0] fv_e;
        bit         chk_cov;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   snap_cnt = 0;

    // Hand-written truth table, index = {x,y,z}.
    logic [7:0] gs1 = 8'b0011_1111;
    logic [7:0] gs2 = 8'b0011_0000;

    task automatic cmp(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, fld, act, req);
        end
    endtask

    // Monitor: pops one expectation per done rising edge or marked checkpoint.
    initial begin
        int   seen;
        logic prev_done;
        exp_t e;
        seen = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if ((snap_cnt != seen) || ((done === 1'b1) && (prev_done !== 1'b1))) begin
                seen = snap_cnt;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output actual=done%0b required=no_output", done);
                end else begin
                    e = exp_q.pop_front();
                    cmp(e.name, "done",     32'(done),            32'(e.done_e));
                    cmp(e.name, "pass",     32'(pass),            32'(e.pass_e));
                    cmp(e.name, "busy",     32'(busy),            32'(e.busy_e));
                    cmp(e.name, "in_ready", 32'(in_ready),        32'(e.ready_e));
                    cmp(e.name, "fev",      32'(first_err_valid), 32'(e.fev_e));
                    cmp(e.name, "err_cnt",  32'(err_cnt),         32'(e.err_e));
                    cmp(e.name, "vec_cnt",  32'(vec_cnt),         32'(e.vec_e));
                    cmp(e.name, "fev_vec",  32'(first_err_vec),   32'(e.fv_e));
                    if (e.chk_cov) begin
                        cmp(e.name, "cov", 32'(cov), 32'(e.cov_e));
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string n, input logic d, input logic p,
                            input logic b, input logic r, input logic fe,
                            input logic [3:0] er, input logic [7:0] v,
                            input logic [7:0] c, input logic [4:0] fv,
                            input bit cc);
        exp_t e;
        e.name = n; e.done_e = d; e.pass_e = p; e.busy_e = b; e.ready_e = r;
        e.fev_e = fe; e.err_e = er; e.vec_e = v; e.cov_e = c; e.fv_e = fv;
        e.chk_cov = cc;
        exp_q.push_back(e);
    endtask

    // Checkpoint: the monitor compares at the next falling edge.
    task automatic snap(input string n, input logic d, input logic p,
                        input logic b, input logic r, input logic fe,
                        input logic [3:0] er, input logic [7:0] v,
                        input logic [7:0] c, input logic [4:0] fv,
                        input bit cc);
        push_exp(n, d, p, b, r, fe, er, v, c, fv, cc);
        snap_cnt++;
    endtask

    task automatic send(input logic vx, input logic vy, input logic vz,
                        input logic vs1, input logic vs2);
        x = vx; y = vy; z = vz; s1 = vs1; s2 = vs2;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic [2:0] m;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
        x = 1'b0; y = 1'b0; z = 1'b0; s1 = 1'b0; s2 = 1'b0;
        tick();
        tick();
        snap("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'h00, 5'd0, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();

        // Vector offered in IDLE is ignored.
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        snap("idle_ignore", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'h00, 5'd0, 1'b1);

        // Golden sweep, then a vector offered in the first DONE cycle.
        push_exp("golden", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd8, 8'hFF, 5'd0, 1'b1);
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            m = 3'(i);
            send(m[2], m[1], m[0], gs1[i], gs2[i]);
        end
        send(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        snap("done_ignore", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd8, 8'hFF, 5'd0, 1'b1);

        // Injected faults: s2=1 at 011, s1=1 at 111.
        pulse_start();
        snap("restart_clear", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 8'h00, 5'd0, 1'b1);
        push_exp("faults", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 8'd8, 8'hFF, 5'b01111, 1'b1);
        for (int i = 0; i < 8; i++) begin
            m = 3'(i);
            if (i == 3) begin
                send(m[2], m[1], m[0], gs1[i], 1'b1);
            end else if (i == 7) begin
                send(m[2], m[1], m[0], 1'b1, gs2[i]);
            end else begin
                send(m[2], m[1], m[0], gs1[i], gs2[i]);
            end
        end

        // Partial coverage then stop.
        pulse_start();
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        push_exp("partial", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd3, 8'h03, 5'd0, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Saturation: 20 vectors at 000 with s1 inverted, then one with z = X.
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        send(1'b0, 1'b0, 1'bx, 1'b1, 1'b0);
        z = 1'b0;
        snap("saturate", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd15, 8'd21, 8'h01, 5'b00000, 1'b0);

        // start in RUN after 5 vectors; the vector offered with start is discarded.
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            m = 3'(i);
            send(m[2], m[1], m[0], gs1[i], gs2[i]);
        end
        x = 1'b1; y = 1'b0; z = 1'b1; s1 = 1'b0; s2 = 1'b0;
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        snap("start_in_run", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0, 8'h00, 5'd0, 1'b1);

        // stop together with a mismatching vector at 110 (s2 wrongly 1).
        push_exp("stop_mismatch", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 8'd1, 8'h40, 5'b11001, 1'b1);
        x = 1'b1; y = 1'b1; z = 1'b0; s1 = 1'b0; s2 = 1'b1;
        stop = 1'b1;
        in_valid = 1'b1;
        tick();
        stop = 1'b0;
        in_valid = 1'b0;

        // Vector offered in DONE is ignored.
        send(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        snap("done_ignore2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 8'd1, 8'h40, 5'b11001, 1'b1);

        // Reset mid-run.
        pulse_start();
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        reset_n = 1'b0;
        tick();
        snap("reset_midrun", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0, 8'h00, 5'd0, 1'b1);
        tick();
        reset_n = 1'b1;
        tick();
        tick();

        // Any expectation still queued means the DUT never produced it.
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s.missing actual=no_output required=output", e.name);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
